alu_arbiter: RTL and testbench

- Shares one 16-bit `alu` instance (ops: add, sub, and, or) between two independent requesters.
- Round-robin arbitration; valid/ready handshake on each request port and on the result port.
- Two registered stages: operand capture (S1), then result register (S2) after the combinational ALU.
- Sits between register-file/sequencer clients and the ALU datapath; throughput one operation per cycle.

---
 rtl/alu_pkg.sv | 33 +++
 rtl/alu_arbiter_if.sv | 57 +++++
 rtl/alu.sv | 40 ++++
 rtl/rr_arb2.sv | 29 ++
 rtl/alu_arbiter.sv | 115 +++++++++++
 tb/tb_alu_arbiter.sv | 388 ++++++++++++++++++++++++++++++++++++++
 6 files changed

// File: rtl/alu_pkg.sv
// Shared constants and pipeline-stage payload types for the ALU arbiter slice.
// Optional macro ALU_FLAGS_EN adds zero/negative/overflow flags to the result stage.
package alu_pkg;

    localparam int ALU_W = 16;
    localparam int ID_W  = 1;

    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_SUB = 2'b01;
    localparam logic [1:0] ALU_AND = 2'b10;
    localparam logic [1:0] ALU_OR  = 2'b11;

    // Operand-capture stage contents.
    typedef struct packed {
        logic [ID_W-1:0]  id;
        logic [1:0]       op;
        logic [ALU_W-1:0] a;
        logic [ALU_W-1:0] b;
    } s1_t;

    // Result-register stage contents.
    typedef struct packed {
        logic [ID_W-1:0]  id;
        logic [ALU_W-1:0] o;
        logic             cout;
`ifdef ALU_FLAGS_EN
        logic             zero;
        logic             neg;
        logic             ovf;
`endif
    } s2_t;

endpackage

// File: rtl/alu_arbiter_if.sv
// Request/result bundle between two ALU clients, the arbiter and the result consumer.
// Handshake: a word moves on any channel in a cycle where valid & ready are both 1 at the rising edge.
// Optional macro ALU_FLAGS_EN adds res_zero/res_neg/res_ovf.
interface alu_arbiter_if
    import alu_pkg::*;
#(
    parameter int W = ALU_W
) ();

    logic         r0_valid;
    logic         r0_ready;
    logic [1:0]   r0_op;
    logic [W-1:0] r0_a;
    logic [W-1:0] r0_b;

    logic         r1_valid;
    logic         r1_ready;
    logic [1:0]   r1_op;
    logic [W-1:0] r1_a;
    logic [W-1:0] r1_b;

    logic         res_valid;
    logic         res_ready;
    logic         res_id;
    logic [W-1:0] res_o;
    logic         res_cout;
`ifdef ALU_FLAGS_EN
    logic         res_zero;
    logic         res_neg;
    logic         res_ovf;
`endif

    modport master (
        output r0_valid, r0_op, r0_a, r0_b,
        input  r0_ready,
        output r1_valid, r1_op, r1_a, r1_b,
        input  r1_ready,
        input  res_valid, res_id, res_o, res_cout,
`ifdef ALU_FLAGS_EN
        input  res_zero, res_neg, res_ovf,
`endif
        output res_ready
    );

    modport slave (
        input  r0_valid, r0_op, r0_a, r0_b,
        output r0_ready,
        input  r1_valid, r1_op, r1_a, r1_b,
        output r1_ready,
        output res_valid, res_id, res_o, res_cout,
`ifdef ALU_FLAGS_EN
        output res_zero, res_neg, res_ovf,
`endif
        input  res_ready
    );

endinterface

// File: rtl/alu.sv
// 16-bit combinational ALU: add, sub (a + ~b + 1), and, or; carry forced to 0 for logic ops.
// Optional macro ALU_FLAGS_EN adds a signed-overflow output.
module alu
    import alu_pkg::*;
(
    input  logic [1:0]       op,
    input  logic [ALU_W-1:0] a,
    input  logic [ALU_W-1:0] b,
    output logic [ALU_W-1:0] o,
`ifdef ALU_FLAGS_EN
    output logic             ovf,
`endif
    output logic             cout
);

    logic [ALU_W-1:0] b_eff;
    logic [ALU_W:0]   sum;

    always_comb begin
        b_eff = (op == ALU_SUB) ? ~b : b;
        sum   = {1'b0, a} + {1'b0, b_eff} + {{ALU_W{1'b0}}, (op == ALU_SUB)};
        o     = '0;
        cout  = 1'b0;
        unique case (op)
            ALU_ADD, ALU_SUB: begin
                o    = sum[ALU_W-1:0];
                cout = sum[ALU_W];
            end
            ALU_AND: o = a & b;
            ALU_OR:  o = a | b;
            default: o = '0;
        endcase
    end

`ifdef ALU_FLAGS_EN
    // Overflow when both addends share a sign that the sum does not.
    assign ovf = ~op[1] & (a[ALU_W-1] == b_eff[ALU_W-1]) & (sum[ALU_W-1] != a[ALU_W-1]);
`endif

endmodule

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter; the last-served pointer moves only when a grant is taken.
module rr_arb2 (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] req,
    input  logic       advance,
    output logic [1:0] grant
);

    logic last_q, last_d;

    always_comb begin
        grant = 2'b00;
        unique case (req)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = last_q ? 2'b01 : 2'b10;
            default: grant = 2'b00;
        endcase
        last_d = advance ? grant[1] : last_q;
    end

    // Reset to "r1 served last" so r0 wins the first contention.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) last_q <= 1'b1;
        else        last_q <= last_d;
    end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one ALU between two requesters: round-robin grant, operand stage S1, result stage S2.
// Optional macro ALU_FLAGS_EN registers res_zero/res_neg/res_ovf in S2 next to the result.
module alu_arbiter
    import alu_pkg::*;
#(
    parameter int W = ALU_W
) (
    input logic          clk,
    input logic          reset,
    alu_arbiter_if.slave bus
);

    if (W != ALU_W) begin : g_width_check
        $error("alu_arbiter: W must be %0d to match the alu instance", ALU_W);
    end

    s1_t        s1_q, s1_d;
    logic       s1_valid_q, s1_valid_d;
    s2_t        s2_q, s2_d;
    logic       s2_valid_q, s2_valid_d;

    logic [1:0] req, grant;
    logic       s2_load, s1_free, xfer0, xfer1;

    logic [ALU_W-1:0] alu_o;
    logic             alu_cout;
`ifdef ALU_FLAGS_EN
    logic             alu_ovf;
`endif

    assign req     = {bus.r1_valid, bus.r0_valid};
    assign s2_load = s1_valid_q & (~s2_valid_q | bus.res_ready);
    assign s1_free = ~s1_valid_q | s2_load;

    assign bus.r0_ready = grant[0] & s1_free & reset;
    assign bus.r1_ready = grant[1] & s1_free & reset;
    assign xfer0 = bus.r0_valid & bus.r0_ready;
    assign xfer1 = bus.r1_valid & bus.r1_ready;

    rr_arb2 u_arb (
        .clk     (clk),
        .reset   (reset),
        .req     (req),
        .advance (xfer0 | xfer1),
        .grant   (grant)
    );

    // The ALU only ever sees registered S1 operands.
    alu u_alu (
        .op   (s1_q.op),
        .a    (s1_q.a),
        .b    (s1_q.b),
        .o    (alu_o),
`ifdef ALU_FLAGS_EN
        .ovf  (alu_ovf),
`endif
        .cout (alu_cout)
    );

    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_d       = s1_q;
        if (xfer0 | xfer1) begin
            s1_valid_d = 1'b1;
            s1_d.id    = ID_W'(xfer1);
            s1_d.op    = xfer1 ? bus.r1_op : bus.r0_op;
            s1_d.a     = xfer1 ? bus.r1_a  : bus.r0_a;
            s1_d.b     = xfer1 ? bus.r1_b  : bus.r0_b;
        end else if (s2_load) begin
            s1_valid_d = 1'b0;
        end

        s2_valid_d = s2_valid_q;
        s2_d       = s2_q;
        if (s2_load) begin
            s2_valid_d = 1'b1;
            s2_d.id    = s1_q.id;
            s2_d.o     = alu_o;
            s2_d.cout  = alu_cout;
`ifdef ALU_FLAGS_EN
            s2_d.zero  = (alu_o == '0);
            s2_d.neg   = alu_o[ALU_W-1];
            s2_d.ovf   = alu_ovf;
`endif
        end else if (bus.res_ready) begin
            s2_valid_d = 1'b0;
        end
    end

    // Reset discards anything in flight; nothing is replayed afterwards.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1_valid_q <= 1'b0;
            s1_q       <= '0;
            s2_valid_q <= 1'b0;
            s2_q       <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_q       <= s1_d;
            s2_valid_q <= s2_valid_d;
            s2_q       <= s2_d;
        end
    end

    assign bus.res_valid = s2_valid_q;
    assign bus.res_id    = s2_q.id;
    assign bus.res_o     = s2_q.o;
    assign bus.res_cout  = s2_q.cout;
`ifdef ALU_FLAGS_EN
    assign bus.res_zero  = s2_q.zero;
    assign bus.res_neg   = s2_q.neg;
    assign bus.res_ovf   = s2_q.ovf;
`endif

endmodule

// File: tb/tb_alu_arbiter.sv
// Randomized scoreboard bench for alu_arbiter: arithmetic reference model, arbitration,
// latency, backpressure and asynchronous-reset checks. Honors ALU_FLAGS_EN when defined.
module tb_alu_arbiter;

    typedef struct {
        logic [1:0]  op;
        logic [15:0] a;
        logic [15:0] b;
    } req_t;

    typedef struct {
        logic        id;
        logic [15:0] o;
        logic        cout;
        logic        zero;
        logic        neg;
        logic        ovf;
        int          cyc;
        bit          strict;
    } exp_t;

    logic clk;
    logic reset;
    logic res_rdy;
    logic vld[2];
    logic [1:0]  op_s[2];
    logic [15:0] a_s[2];
    logic [15:0] b_s[2];
    bit   took[2];

    req_t pend0[$];
    req_t pend1[$];
    exp_t exp_q[$];

    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;
    int last_served = 1;
    bit strict_mode = 0;
    bit rand_rr = 0;
    bit rand_gap = 0;

    alu_arbiter_if #(.W(16)) bus ();

    assign bus.r0_valid  = vld[0];
    assign bus.r0_op     = op_s[0];
    assign bus.r0_a      = a_s[0];
    assign bus.r0_b      = b_s[0];
    assign bus.r1_valid  = vld[1];
    assign bus.r1_op     = op_s[1];
    assign bus.r1_a      = a_s[1];
    assign bus.r1_b      = b_s[1];
    assign bus.res_ready = res_rdy;

    alu_arbiter dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // ---------------- clock / reset ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    // ---------------- reference model ----------------
    function automatic exp_t model(input int id, input logic [1:0] op,
                                   input logic [15:0] a, input logic [15:0] b);
        exp_t m;
        int unsigned ua, ub;
        int sa, sb, s;
        ua = a;
        ub = b;
        sa = $signed(a);
        sb = $signed(b);
        m.id = (id != 0);
        m.ovf = 1'b0;
        case (op)
            2'd0: begin
                m.o = 16'(ua + ub);
                m.cout = (ua + ub) > 65535;
                s = sa + sb;
                m.ovf = (s > 32767) || (s < -32768);
            end
            2'd1: begin
                m.o = 16'(ua + 65536 - ub);
                m.cout = (ua >= ub);
                s = sa - sb;
                m.ovf = (s > 32767) || (s < -32768);
            end
            2'd2: begin
                m.o = a & b;
                m.cout = 1'b0;
            end
            default: begin
                m.o = a | b;
                m.cout = 1'b0;
            end
        endcase
        m.zero = (m.o == 16'h0000);
        m.neg = m.o[15];
        m.cyc = 0;
        m.strict = 1'b0;
        return m;
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    // ---------------- driver ----------------
    initial begin : driver
        req_t r;
        bit go;
        int sz;
        forever begin
            @(posedge clk);
            #1;
            if (reset) begin
                if (rand_rr) res_rdy = ($urandom_range(0, 3) != 0);
                for (int p = 0; p < 2; p++) begin
                    if (took[p]) begin
                        vld[p] = 1'b0;
                        took[p] = 1'b0;
                        if (p == 0) void'(pend0.pop_front());
                        else        void'(pend1.pop_front());
                    end
                    go = !rand_gap || ($urandom_range(0, 3) != 0);
                    sz = (p == 0) ? pend0.size() : pend1.size();
                    if (!vld[p] && go && sz > 0) begin
                        r = (p == 0) ? pend0[0] : pend1[0];
                        vld[p] = 1'b1;
                        op_s[p] = r.op;
                        a_s[p] = r.a;
                        b_s[p] = r.b;
                    end
                end
            end
        end
    end

    // ---------------- acceptance observer: arbitration + expected push ----------------
    initial begin : observer
        logic rd[2];
        exp_t e;
        forever begin
            @(negedge clk);
            rd[0] = bus.r0_ready;
            rd[1] = bus.r1_ready;
            if (reset) begin
                for (int p = 0; p < 2; p++)
                    if (rd[p]) check("ready_needs_valid", 32'(vld[p]), 32'd1);
                if (vld[0] && vld[1] && (rd[0] || rd[1])) begin
                    check("contention_winner", rd[0] && rd[1] ? 32'd2 : (rd[1] ? 32'd1 : 32'd0),
                          (last_served == 0) ? 32'd1 : 32'd0);
                end
                for (int p = 0; p < 2; p++) begin
                    if (vld[p] && rd[p]) begin
                        took[p] = 1'b1;
                        e = model(p, op_s[p], a_s[p], b_s[p]);
                        e.cyc = cyc;
                        e.strict = strict_mode;
                        exp_q.push_back(e);
                        last_served = p;
                    end
                end
            end
        end
    end

    // ---------------- result monitor ----------------
    initial begin : monitor
        exp_t e;
        bit hold = 0;
        logic [31:0] held, now_v;
        forever begin
            @(negedge clk);
            if (!reset) begin
                hold = 0;
            end else begin
`ifdef ALU_FLAGS_EN
                now_v = {10'd0, bus.res_zero, bus.res_neg, bus.res_ovf,
                         bus.res_valid, bus.res_id, bus.res_cout, bus.res_o};
`else
                now_v = {13'd0, bus.res_valid, bus.res_id, bus.res_cout, bus.res_o};
`endif
                if (hold) check("stall_stable", now_v, held);
                if (bus.res_valid && bus.res_ready) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_result", 32'd1, 32'd0);
                    end else begin
                        e = exp_q.pop_front();
`ifdef ALU_FLAGS_EN
                        check("result", now_v, {10'd0, e.zero, e.neg, e.ovf, 1'b1, e.id, e.cout, e.o});
`else
                        check("result", now_v, {13'd0, 1'b1, e.id, e.cout, e.o});
`endif
                        if (e.strict) check("latency", 32'(cyc - e.cyc), 32'd2);
                    end
                end
                hold = bus.res_valid && !bus.res_ready;
                held = now_v;
            end
        end
    end

    // ---------------- sequence helpers ----------------
    task automatic wait_drain(input string name, input int budget);
        int n = 0;
        while (pend0.size() != 0 || pend1.size() != 0 || vld[0] || vld[1] || exp_q.size() != 0) begin
            @(posedge clk);
            #2;
            n++;
            if (n > budget) break;
        end
        check(name, 32'(n > budget), 32'd0);
        if (n > budget) begin
            pend0.delete();
            pend1.delete();
            exp_q.delete();
        end
    endtask

    function automatic req_t rnd_req();
        req_t r;
        r.op = 2'($urandom_range(0, 3));
        r.a = 16'($urandom);
        r.b = 16'($urandom);
        if ($urandom_range(0, 7) == 0) r.b = r.a;
        return r;
    endfunction

    function automatic req_t mk(input logic [1:0] op, input logic [15:0] a, input logic [15:0] b);
        req_t r;
        r.op = op;
        r.a = a;
        r.b = b;
        return r;
    endfunction

    // ---------------- main sequence ----------------
    initial begin : main
        int c0;
        reset = 1'b0;
        res_rdy = 1'b0;
        for (int p = 0; p < 2; p++) begin
            vld[p] = 1'b1;
            op_s[p] = 2'd0;
            a_s[p] = 16'h1234;
            b_s[p] = 16'h4321;
            took[p] = 1'b0;
        end

        // Reset state with both requesters pushing.
        #8;
        check("rst_res_valid", 32'(bus.res_valid), 32'd0);
        check("rst_res_o", 32'(bus.res_o), 32'd0);
        check("rst_res_cout", 32'(bus.res_cout), 32'd0);
        check("rst_res_id", 32'(bus.res_id), 32'd0);
        #10;
        check("rst_readies", {30'd0, bus.r1_ready, bus.r0_ready}, 32'd0);
`ifdef ALU_FLAGS_EN
        check("rst_flags", {29'd0, bus.res_zero, bus.res_neg, bus.res_ovf}, 32'd0);
`endif
        #3;
        vld[0] = 1'b0;
        vld[1] = 1'b0;
        #1;
        reset = 1'b1;
        res_rdy = 1'b1;
        strict_mode = 1'b1;

        // Directed vectors from the test plan.
        pend0.push_back(mk(2'b00, 16'h0001, 16'hFFFF));
        pend0.push_back(mk(2'b10, 16'hF0F0, 16'h0FF0));
        pend0.push_back(mk(2'b11, 16'hF0F0, 16'h0FF0));
        pend1.push_back(mk(2'b01, 16'h0005, 16'h0007));
        pend1.push_back(mk(2'b01, 16'h0007, 16'h0005));
        pend1.push_back(mk(2'b00, 16'h7FFF, 16'h0001));
        pend1.push_back(mk(2'b01, 16'h8000, 16'h0001));
        wait_drain("drain_directed", 100);

        // Continuous contention: alternate grants, one result per cycle.
        @(posedge clk);
        #2;
        for (int i = 0; i < 20; i++) begin
            pend0.push_back(rnd_req());
            pend1.push_back(rnd_req());
        end
        c0 = cyc;
        wait_drain("drain_contention", 200);
        check("contention_rate", 32'(cyc - c0 <= 45), 32'd1);

        // Backpressure: 3 requests offered with res_ready low.
        @(posedge clk);
        #2;
        strict_mode = 1'b0;
        res_rdy = 1'b0;
        pend0.push_back(rnd_req());
        pend1.push_back(rnd_req());
        pend0.push_back(rnd_req());
        repeat (5) @(posedge clk);
        #3;
        check("bp_readies", {30'd0, bus.r1_ready, bus.r0_ready}, 32'd0);
        check("bp_res_valid", 32'(bus.res_valid), 32'd1);
        check("bp_third_waiting", 32'(pend0.size() + pend1.size()), 32'd1);
        check("bp_in_flight", 32'(exp_q.size()), 32'd2);
        res_rdy = 1'b1;
        wait_drain("drain_backpressure", 50);

        // Random traffic with random gaps and random backpressure.
        @(posedge clk);
        #2;
        rand_rr = 1'b1;
        rand_gap = 1'b1;
        for (int i = 0; i < 150; i++) begin
            pend0.push_back(rnd_req());
            pend1.push_back(rnd_req());
        end
        wait_drain("drain_random", 3000);
        rand_rr = 1'b0;
        rand_gap = 1'b0;
        res_rdy = 1'b1;

        // Asynchronous reset with S1 and S2 full.
        @(posedge clk);
        #2;
        res_rdy = 1'b0;
        pend0.push_back(rnd_req());
        pend1.push_back(rnd_req());
        pend0.push_back(rnd_req());
        repeat (5) @(posedge clk);
        #2;
        check("pre_rst_full", {30'd0, bus.res_valid, bus.r0_ready | bus.r1_ready}, 32'd2);
        reset = 1'b0;
        #1;
        check("arst_res_valid", 32'(bus.res_valid), 32'd0);
        check("arst_res_o", 32'(bus.res_o), 32'd0);
        check("arst_res_cout_id", {30'd0, bus.res_cout, bus.res_id}, 32'd0);
        check("arst_readies", {30'd0, bus.r1_ready, bus.r0_ready}, 32'd0);
        exp_q.delete();
        last_served = 1;
        repeat (2) @(posedge clk);
        #3;
        check("arst_readies_held", {30'd0, bus.r1_ready, bus.r0_ready}, 32'd0);
        pend0.delete();
        pend1.delete();
        vld[0] = 1'b0;
        vld[1] = 1'b0;
        took[0] = 1'b0;
        took[1] = 1'b0;
        @(negedge clk);
        #2;
        reset = 1'b1;
        res_rdy = 1'b1;
        strict_mode = 1'b1;
        pend0.push_back(rnd_req());
        pend1.push_back(rnd_req());
        pend0.push_back(rnd_req());
        pend1.push_back(rnd_req());
        wait_drain("drain_after_reset", 50);
        repeat (4) @(posedge clk);
        #3;
        check("no_stale_result", 32'(bus.res_valid), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
